// File: rtl/pipeline_hazard_controller.sv
// Stall/flush sequencer for a 5-stage RV32IM pipeline: load-use, EX redirect and
// multi-cycle MUL/DIV hazards, WB-forward selects, MUL/DIV watchdog, stall counter.
module pipeline_hazard_controller #(
    parameter int MD_TIMEOUT = 40,
    parameter int CNT_W      = 16
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             id_ex_mem_read,
    input  logic [4:0]       id_ex_rd,
    input  logic [4:0]       if_id_rs1,
    input  logic [4:0]       if_id_rs2,
    input  logic             rs1_used,
    input  logic             rs2_used,
    input  logic             branch_taken,
    input  logic             muldiv_start,
    input  logic             muldiv_done,
    output logic             pc_write_en,
    output logic             if_id_write_en,
    output logic             if_id_flush,
    output logic             id_ex_bubble,
    output logic             ex_hold,
    output logic             forward_wb_rs1,
    output logic             forward_wb_rs2,
    output logic             md_timeout,
    output logic [CNT_W-1:0] stall_cycles
);

    localparam int MD_W = $clog2(MD_TIMEOUT + 1);

    typedef enum logic {RUN, MD_WAIT} state_t;

    state_t          state;
    logic [MD_W-1:0] md_cnt;

    logic lu_rs1;
    logic lu_rs2;
    logic lu;
    logic md_hold_start;
    logic lu_stall;
    logic md_abort;

    // x0 is hard-wired zero, so a load targeting it never creates a hazard.
    assign lu_rs1        = rs1_used & (if_id_rs1 == id_ex_rd);
    assign lu_rs2        = rs2_used & (if_id_rs2 == id_ex_rd);
    assign lu            = id_ex_mem_read & (id_ex_rd != 5'd0) & (lu_rs1 | lu_rs2);
    assign md_hold_start = muldiv_start & ~muldiv_done;
    assign lu_stall      = (state == RUN) & ~branch_taken & ~md_hold_start & lu;
    // md_cnt already counts the hold cycles before this one, so this is the last allowed.
    assign md_abort      = (int'(md_cnt) + 1) >= MD_TIMEOUT;

    always_comb begin
        pc_write_en    = 1'b1;
        if_id_write_en = 1'b1;
        if_id_flush    = 1'b0;
        id_ex_bubble   = 1'b0;
        ex_hold        = 1'b0;
        if (RESET) begin
            if (state == RUN) begin
                if (branch_taken) begin
                    if_id_flush  = 1'b1;
                    id_ex_bubble = 1'b1;
                end else if (md_hold_start) begin
                    ex_hold        = 1'b1;
                    pc_write_en    = 1'b0;
                    if_id_write_en = 1'b0;
                end else if (lu) begin
                    pc_write_en    = 1'b0;
                    if_id_write_en = 1'b0;
                    id_ex_bubble   = 1'b1;
                end
            end else if (!muldiv_done) begin
                ex_hold        = 1'b1;
                pc_write_en    = 1'b0;
                if_id_write_en = 1'b0;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (!RESET) begin
            state          <= RUN;
            md_cnt         <= '0;
            forward_wb_rs1 <= 1'b0;
            forward_wb_rs2 <= 1'b0;
            md_timeout     <= 1'b0;
            stall_cycles   <= '0;
        end else begin
            forward_wb_rs1 <= lu_stall & lu_rs1;
            forward_wb_rs2 <= lu_stall & lu_rs2;
            if (!pc_write_en && (stall_cycles != '1))
                stall_cycles <= stall_cycles + 1'b1;
            if (state == RUN) begin
                if (!branch_taken && md_hold_start) begin
                    state  <= MD_WAIT;
                    md_cnt <= MD_W'(1);
                end
            end else begin
                if (muldiv_done) begin
                    state  <= RUN;
                    md_cnt <= '0;
                end else if (md_abort) begin
                    state      <= RUN;
                    md_cnt     <= '0;
                    md_timeout <= 1'b1;
                end else begin
                    md_cnt <= md_cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Scoreboard bench: the driver queues hand-computed expectations per cycle, the
// monitor compares them on the falling edge. A CNT_W=4 copy exercises saturation.
module tb_pipeline_hazard_controller;

    logic       CLK;
    logic       RESET;
    logic       id_ex_mem_read;
    logic [4:0] id_ex_rd;
    logic [4:0] if_id_rs1;
    logic [4:0] if_id_rs2;
    logic       rs1_used;
    logic       rs2_used;
    logic       branch_taken;
    logic       muldiv_start;
    logic       muldiv_done;

    logic        pc_write_en, if_id_write_en, if_id_flush, id_ex_bubble, ex_hold;
    logic        forward_wb_rs1, forward_wb_rs2, md_timeout;
    logic [15:0] stall_cycles;

    logic        pc_write_en4, if_id_write_en4, if_id_flush4, id_ex_bubble4, ex_hold4;
    logic        forward_wb_rs14, forward_wb_rs24, md_timeout4;
    logic [3:0]  stall_cycles4;

    pipeline_hazard_controller #(.MD_TIMEOUT(40), .CNT_W(16)) dut (
        .CLK(CLK), .RESET(RESET),
        .id_ex_mem_read(id_ex_mem_read), .id_ex_rd(id_ex_rd),
        .if_id_rs1(if_id_rs1), .if_id_rs2(if_id_rs2),
        .rs1_used(rs1_used), .rs2_used(rs2_used),
        .branch_taken(branch_taken), .muldiv_start(muldiv_start), .muldiv_done(muldiv_done),
        .pc_write_en(pc_write_en), .if_id_write_en(if_id_write_en),
        .if_id_flush(if_id_flush), .id_ex_bubble(id_ex_bubble), .ex_hold(ex_hold),
        .forward_wb_rs1(forward_wb_rs1), .forward_wb_rs2(forward_wb_rs2),
        .md_timeout(md_timeout), .stall_cycles(stall_cycles)
    );

    pipeline_hazard_controller #(.MD_TIMEOUT(40), .CNT_W(4)) dut4 (
        .CLK(CLK), .RESET(RESET),
        .id_ex_mem_read(id_ex_mem_read), .id_ex_rd(id_ex_rd),
        .if_id_rs1(if_id_rs1), .if_id_rs2(if_id_rs2),
        .rs1_used(rs1_used), .rs2_used(rs2_used),
        .branch_taken(branch_taken), .muldiv_start(muldiv_start), .muldiv_done(muldiv_done),
        .pc_write_en(pc_write_en4), .if_id_write_en(if_id_write_en4),
        .if_id_flush(if_id_flush4), .id_ex_bubble(id_ex_bubble4), .ex_hold(ex_hold4),
        .forward_wb_rs1(forward_wb_rs14), .forward_wb_rs2(forward_wb_rs24),
        .md_timeout(md_timeout4), .stall_cycles(stall_cycles4)
    );

    typedef struct {
        string      nm;
        logic [7:0] ctl;   // {pc_we, if_id_we, flush, bubble, hold, fwd1, fwd2, timeout}
        int         cnt;
        int         cnt4;
    } exp_t;

    exp_t q[$];
    int   n_vec  = 0;
    int   n_miss = 0;

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic vec(input string nm, input logic rst, input logic mr,
                       input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic u1, input logic u2, input logic bt,
                       input logic ms, input logic md,
                       input logic [7:0] ctl, input int cnt, input int cnt4);
        @(posedge CLK);
        #1;
        RESET          = rst;
        id_ex_mem_read = mr;
        id_ex_rd       = rd;
        if_id_rs1      = rs1;
        if_id_rs2      = rs2;
        rs1_used       = u1;
        rs2_used       = u2;
        branch_taken   = bt;
        muldiv_start   = ms;
        muldiv_done    = md;
        q.push_back('{nm, ctl, cnt, cnt4});
    endtask

    task automatic idle(input string nm, input logic [7:0] ctl, input int cnt, input int cnt4);
        vec(nm, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, ctl, cnt, cnt4);
    endtask

    // Monitor: every cycle is an output beat; compare whatever the driver queued.
    initial begin
        exp_t       e;
        logic [7:0] act;
        logic [7:0] act4;
        forever begin
            @(negedge CLK);
            if (q.size() != 0) begin
                e    = q.pop_front();
                act  = {pc_write_en, if_id_write_en, if_id_flush, id_ex_bubble, ex_hold,
                        forward_wb_rs1, forward_wb_rs2, md_timeout};
                act4 = {pc_write_en4, if_id_write_en4, if_id_flush4, id_ex_bubble4, ex_hold4,
                        forward_wb_rs14, forward_wb_rs24, md_timeout4};
                n_vec++;
                if (act !== e.ctl || act4 !== e.ctl ||
                    stall_cycles !== 16'(e.cnt) || stall_cycles4 !== 4'(e.cnt4)) begin
                    n_miss++;
                    $display("FAIL %s: got ctl=%b ctl4=%b cnt=%0d cnt4=%0d, expected ctl=%b cnt=%0d cnt4=%0d",
                             e.nm, act, act4, stall_cycles, stall_cycles4, e.ctl, e.cnt, e.cnt4);
                end
            end
        end
    end

    initial begin
        RESET          = 1'b0;
        id_ex_mem_read = 1'b0;
        id_ex_rd       = 5'd0;
        if_id_rs1      = 5'd0;
        if_id_rs2      = 5'd0;
        rs1_used       = 1'b0;
        rs2_used       = 1'b0;
        branch_taken   = 1'b0;
        muldiv_start   = 1'b0;
        muldiv_done    = 1'b0;

        // Reset held with hazard-looking inputs: outputs stay idle
        vec("rst_lu_md", 1'b0, 1'b1, 5'd5, 5'd5, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'b11000000, 0, 0);
        vec("rst_br_md", 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'b11000000, 0, 0);
        idle("post_rst", 8'b11000000, 0, 0);

        // Load-use
        vec("lu_rs1", 1'b1, 1'b1, 5'd5, 5'd5, 5'd7, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'b00010000, 0, 0);
        idle("lu_fwd1", 8'b11000100, 1, 1);
        vec("lu_rd0", 1'b1, 1'b1, 5'd0, 5'd0, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'b11000000, 1, 1);
        vec("lu_both", 1'b1, 1'b1, 5'd9, 5'd9, 5'd9, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'b00010000, 1, 1);
        vec("lu_unused", 1'b1, 1'b1, 5'd9, 5'd9, 5'd9, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'b11000110, 2, 2);
        vec("lu_rs2", 1'b1, 1'b1, 5'd3, 5'd4, 5'd3, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'b00010000, 2, 2);

        // Branch wins over load-use, no stall counted
        vec("br_vs_lu", 1'b1, 1'b1, 5'd5, 5'd5, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'b11110010, 3, 3);
        idle("after_br", 8'b11000000, 3, 3);

        // MUL/DIV: start, 4 wait cycles (branch/lu ignored), done on 6th cycle
        vec("md_start", 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'b00001000, 3, 3);
        idle("md_wait1", 8'b00001000, 4, 4);
        vec("md_wait_ign", 1'b1, 1'b1, 5'd6, 5'd6, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'b00001000, 5, 5);
        idle("md_wait3", 8'b00001000, 6, 6);
        idle("md_wait4", 8'b00001000, 7, 7);
        vec("md_done", 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'b11000000, 8, 8);
        idle("md_back_run", 8'b11000000, 8, 8);
        vec("md_single", 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'b11000000, 8, 8);
        idle("md_single_nx", 8'b11000000, 8, 8);

        // Reset during the 3rd MD_WAIT cycle
        vec("mr_start", 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'b00001000, 8, 8);
        idle("mr_wait1", 8'b00001000, 9, 9);
        idle("mr_wait2", 8'b00001000, 10, 10);
        vec("mr_reset", 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'b11000000, 11, 11);
        idle("mr_after", 8'b11000000, 0, 0);

        // Watchdog: 40 hold cycles then abort; the CNT_W=4 copy saturates at 15
        vec("wd_start", 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'b00001000, 0, 0);
        for (int k = 1; k <= 39; k++)
            idle("wd_hold", 8'b00001000, k, (k > 15) ? 15 : k);
        idle("wd_abort", 8'b11000001, 40, 15);
        idle("wd_sticky", 8'b11000001, 40, 15);
        vec("wd_lu_run", 1'b1, 1'b1, 5'd8, 5'd8, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'b00010001, 40, 15);
        vec("wd_rst", 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'b11000101, 41, 15);
        idle("wd_cleared", 8'b11000000, 0, 0);

        for (int w = 0; w < 5 && q.size() != 0; w++)
            @(negedge CLK);
        @(negedge CLK);
        #1;
        if (q.size() != 0) begin
            n_miss++;
            $display("FAIL drain: %0d expectations left, required 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/pipeline_hazard_controller.md
Name: pipeline_hazard_controller

Overview:
Central stall/flush sequencer for the RV32IM 5-stage pipeline (IF/ID/EX/MEM/WB). It combines three hazard sources into one set of pipeline-register enable, flush and bubble controls: load-use, taken branch/jump resolved in EX, and multi-cycle MUL/DIV occupying EX. It registers WB-forward selects for the instruction released after a load-use stall, runs a MUL/DIV watchdog, and keeps a saturating stall-cycle counter.

Parameters:
MD_TIMEOUT, 40, max cycles in MD_WAIT before watchdog abort
CNT_W, 16, width of stall_cycles counter

Ports:
CLK  in  1  clock, all state updates on rising edge
RESET  in  1  synchronous, active-low reset
id_ex_mem_read  in  1  instruction in ID/EX is a load
id_ex_rd  in  5  destination register of ID/EX instruction
if_id_rs1  in  5  rs1 of instruction in IF/ID
if_id_rs2  in  5  rs2 of instruction in IF/ID
rs1_used  in  1  IF/ID instruction reads rs1
rs2_used  in  1  IF/ID instruction reads rs2
branch_taken  in  1  EX resolved taken branch/jump (redirect this cycle)
muldiv_start  in  1  EX holds a MUL/DIV op needing >1 cycle (level, first cycle)
muldiv_done  in  1  MUL/DIV unit result valid this cycle
pc_write_en  out  1  PC update enable
if_id_write_en  out  1  IF/ID register enable
if_id_flush  out  1  clear IF/ID to NOP
id_ex_bubble  out  1  load NOP into ID/EX
ex_hold  out  1  freeze ID/EX and EX/MEM (insert NOP into EX/MEM)
forward_wb_rs1  out  1  registered: next ID-read of rs1 takes WB value
forward_wb_rs2  out  1  registered: next ID-read of rs2 takes WB value
md_timeout  out  1  sticky watchdog error flag
stall_cycles  out  CNT_W  saturating count of cycles with pc_write_en=0

Behaviour:
- Clock CLK, reset RESET synchronous active-low; RESET=0 at a rising edge forces state=RUN, md_cnt=0, forward_wb_rs1/2=0, md_timeout=0, stall_cycles=0. Reset mid-MD_WAIT returns to RUN immediately, with no pending hold.
- Outputs pc_write_en, if_id_write_en, if_id_flush, id_ex_bubble and ex_hold are combinational from state and inputs. While RESET=0 they hold idle values: enables=1, all others=0.
- Load-use match: lu = id_ex_mem_read & (id_ex_rd!=0) & ((rs1_used & rs1==rd) | (rs2_used & rs2==rd)). x0 never matches.
- States: RUN, MD_WAIT.
- RUN priority, highest first:
  1. branch_taken: if_id_flush=1, id_ex_bubble=1, pc_write_en=1. lu is ignored and no stall is counted.
  2. muldiv_start & ~muldiv_done: ex_hold=1, pc_write_en=0, if_id_write_en=0; next state=MD_WAIT, md_cnt=1.
  3. lu: pc_write_en=0, if_id_write_en=0, id_ex_bubble=1 for exactly 1 cycle. Stay in RUN.
  4. Otherwise all enables=1, others=0.
- muldiv_start & muldiv_done together (single-cycle op) produce no hold.
- MD_WAIT:
  - ex_hold=1, pc_write_en=0, if_id_write_en=0; branch_taken and lu are ignored.
  - On muldiv_done: outputs are idle in that same cycle, next state=RUN, md_cnt=0.
  - Otherwise md_cnt increments. When md_cnt==MD_TIMEOUT with no done: set md_timeout=1 (sticky until reset), next state=RUN.
- Forward flags: at each edge, forward_wb_rs1 <= lu-stall-taken & rs1_used & (rs1==rd), and likewise for rs2. They are 1 only in the cycle after a load-use stall; otherwise 0. Both may be 1 at once.
- stall_cycles increments on every edge where pc_write_en=0 and RESET=1. It saturates at 2^CNT_W-1 with no wrap.

Test Plan:
- Reset: hold RESET=0 for 2 edges with random inputs -> all registered outputs 0, pc_write_en=1, stall_cycles=0.
- Load-use: id_ex_mem_read=1, rd=5, rs1=5, rs1_used=1 -> one cycle with pc_write_en=0 and id_ex_bubble=1; next cycle forward_wb_rs1=1, forward_wb_rs2=0; stall_cycles=1. Repeat with rd=0 -> no stall.
- Branch vs load-use: branch_taken=1 with a load-use match in the same cycle -> if_id_flush=1, id_ex_bubble=1, pc_write_en=1, stall_cycles unchanged.
- MUL/DIV: muldiv_start=1, then muldiv_done on the 6th cycle -> ex_hold=1 for 5 cycles, back in RUN with pc_write_en=1, stall_cycles=5. With start and done in the same cycle -> no hold.
- Watchdog: MD_TIMEOUT=40, muldiv_start with done never asserted -> md_timeout=1 after 40 hold cycles, state RUN; md_timeout stays 1 until RESET=0.
- Reset mid-op and saturation: RESET=0 in the 3rd MD_WAIT cycle -> next cycle ex_hold=0. With CNT_W=4, 20 stall cycles -> stall_cycles=15.
